// File: rtl/det_pkg.sv
// Shared types and width helpers for the sequential Leibniz determinant unit
// and its Heap's-algorithm permutation generator.
package det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_ACC,   // accumulation happens in the last MUL cycle; never entered
        ST_DONE
    } state_t;

    function automatic int factorial(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) begin
            f = f * i;
        end
        return f;
    endfunction

    // Width of the running product of MAX_N elements (sign included).
    function automatic int prod_w_of(input int max_n, input int elem_w);
        return max_n * elem_w;
    endfunction

    // Width of a sum of MAX_N! products that can never overflow.
    function automatic int acc_w_of(input int max_n, input int elem_w);
        return prod_w_of(max_n, elem_w) + $clog2(factorial(max_n)) + 1;
    endfunction

    function automatic int perm_idx_w_of(input int max_n);
        return (max_n > 1) ? $clog2(max_n) : 1;
    endfunction

    // Counter width able to hold values 0..max_n inclusive.
    function automatic int cnt_w_of(input int max_n);
        return $clog2(max_n + 1);
    endfunction

endpackage

// File: rtl/heap_perm_gen.sv
// Iterative Heap's-algorithm permutation generator. The emitted permutation
// is held in perm while the next one is precomputed in a working copy.
module heap_perm_gen
    import det_pkg::*;
#(
    parameter int MAX_N = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   init,
    input  logic                                   step,
    input  logic [cnt_w_of(MAX_N)-1:0]             n,
    output logic [MAX_N*perm_idx_w_of(MAX_N)-1:0]  perm,
    output logic                                   parity,
    output logic                                   last
);

    localparam int IDX_W = perm_idx_w_of(MAX_N);
    localparam int CNT_W = cnt_w_of(MAX_N);

    logic [IDX_W-1:0] work_reg  [MAX_N];
    logic [IDX_W-1:0] work_next [MAX_N];
    logic [IDX_W-1:0] cur_reg   [MAX_N];
    logic [CNT_W-1:0] c_reg     [MAX_N];
    logic [CNT_W-1:0] c_next    [MAX_N];
    logic [CNT_W-1:0] i_reg, i_next;
    logic             ready_reg, ready_next;
    logic             exh_reg, exh_next;
    logic             parity_reg;
    logic             advance;
    logic [IDX_W-1:0] i_idx, swap_idx;

    assign i_idx   = IDX_W'(i_reg);
    // Work on the next permutation whenever it is not yet ready, including
    // on the very edge the current one is handed out.
    assign advance = (step || !ready_reg) && !exh_reg;

    always_comb begin
        work_next  = work_reg;
        c_next     = c_reg;
        i_next     = i_reg;
        ready_next = ready_reg && !step;
        exh_next   = exh_reg;
        swap_idx   = '0;
        if (advance) begin
            if (c_reg[i_idx] < i_reg) begin
                swap_idx            = i_reg[0] ? IDX_W'(c_reg[i_idx]) : '0;
                work_next[swap_idx] = work_reg[i_idx];
                work_next[i_idx]    = work_reg[swap_idx];
                c_next[i_idx]       = c_reg[i_idx] + CNT_W'(1);
                i_next              = CNT_W'(1);
                ready_next          = 1'b1;
            end else begin
                c_next[i_idx] = '0;
                i_next        = i_reg + CNT_W'(1);
                exh_next      = (i_reg + CNT_W'(1)) >= n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            for (int k = 0; k < MAX_N; k++) begin
                work_reg[k] <= IDX_W'(k);
                cur_reg[k]  <= IDX_W'(k);
                c_reg[k]    <= '0;
            end
            i_reg      <= CNT_W'(1);
            ready_reg  <= 1'b0;
            exh_reg    <= 1'b0;
            parity_reg <= 1'b0;
        end else begin
            work_reg  <= work_next;
            c_reg     <= c_next;
            i_reg     <= i_next;
            ready_reg <= ready_next;
            exh_reg   <= exh_next;
            if (step) begin
                cur_reg    <= work_reg;
                parity_reg <= ~parity_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_N; gi++) begin : g_perm
            assign perm[gi*IDX_W +: IDX_W] = cur_reg[gi];
        end
    endgenerate

    assign parity = parity_reg;
    assign last   = exh_reg && !ready_reg;

endmodule

// File: rtl/determinante_seq.sv
// Sequential Leibniz determinant: one element multiply per cycle over all
// Heap's permutations. DET_OVERFLOW_CHECK_EN widens the accumulator and
// enables the overflow flag; otherwise the sum wraps in DET_W bits.
module determinante_seq
    import det_pkg::*;
#(
    parameter int MAX_N  = 5,
    parameter int ELEM_W = 8,
    parameter int DET_W  = 32,
    parameter int SIZE_W = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SIZE_W-1:0]               sinalizador,
    input  logic [MAX_N*MAX_N*ELEM_W-1:0]   matriz,
    output logic                            busy,
    output logic                            done,
    output logic [DET_W-1:0]                det,
    output logic                            err,
    output logic                            overflow
);

    localparam int PROD_W = prod_w_of(MAX_N, ELEM_W);
    localparam int IDX_W  = perm_idx_w_of(MAX_N);
    localparam int CNT_W  = cnt_w_of(MAX_N);
    localparam int N_W    = SIZE_W + 1;
    localparam int NUM_EL = MAX_N * MAX_N;
    localparam int WORD_W = $clog2(NUM_EL);
`ifdef DET_OVERFLOW_CHECK_EN
    localparam int ACC_W  = acc_w_of(MAX_N, ELEM_W);
`else
    localparam int ACC_W  = DET_W;
`endif
    localparam logic signed [PROD_W-1:0] PROD_ONE     = PROD_W'(1);
    localparam logic signed [PROD_W-1:0] PROD_NEG_ONE = '1;

    state_t                          state_reg, state_next;
    logic [MAX_N*MAX_N*ELEM_W-1:0]   mat_reg;
    logic [N_W-1:0]                  n_reg, j_reg;
    logic signed [PROD_W-1:0]        prod_reg;
    logic signed [ACC_W-1:0]         acc_reg;
    logic                            busy_reg, done_reg, err_reg, ovf_reg;
    logic                            job_err_reg;
    logic [DET_W-1:0]                det_reg;

    logic [N_W-1:0]                  n_in;
    logic                            bad_n;
    logic                            last_mul;
    logic                            gen_init, gen_step;
    logic [MAX_N*IDX_W-1:0]          gen_perm;
    logic                            gen_parity, gen_last;
    logic [CNT_W-1:0]                gen_n;
    logic [IDX_W-1:0]                perm_arr [MAX_N];
    logic [IDX_W-1:0]                perm_j;
    logic signed [ELEM_W-1:0]        words [NUM_EL];
    logic [WORD_W-1:0]               n_w, k_w, word_idx;
    logic signed [ELEM_W-1:0]        elem;
    logic signed [PROD_W-1:0]        elem_ext, prod_mul;
    logic signed [ACC_W-1:0]         acc_term;
    logic                            ovf_now;

    assign n_in     = N_W'(sinalizador) + N_W'(2);
    assign bad_n    = int'(n_in) > MAX_N;
    assign last_mul = (j_reg == n_reg - N_W'(1));
    assign gen_n    = CNT_W'(n_reg);

    heap_perm_gen #(
        .MAX_N (MAX_N)
    ) u_gen (
        .clk    (clk),
        .rst    (rst),
        .init   (gen_init),
        .step   (gen_step),
        .n      (gen_n),
        .perm   (gen_perm),
        .parity (gen_parity),
        .last   (gen_last)
    );

    genvar gi;
    generate
        // words[] is indexed from the LSB end of the latched matrix.
        for (gi = 0; gi < NUM_EL; gi++) begin : g_words
            assign words[gi] = mat_reg[gi*ELEM_W +: ELEM_W];
        end
        for (gi = 0; gi < MAX_N; gi++) begin : g_perm
            assign perm_arr[gi] = gen_perm[gi*IDX_W +: IDX_W];
        end
    endgenerate

    // Element a[j][perm[j]] lives at word n*n-1-(j*n+perm[j]) from the LSB.
    assign perm_j   = perm_arr[IDX_W'(j_reg)];
    assign n_w      = WORD_W'(n_reg);
    assign k_w      = WORD_W'(j_reg) * n_w + WORD_W'(perm_j);
    assign word_idx = n_w * n_w - WORD_W'(1) - k_w;
    assign elem     = words[word_idx];
    assign elem_ext = {{(PROD_W-ELEM_W){elem[ELEM_W-1]}}, elem};
    assign prod_mul = prod_reg * elem_ext;

    generate
        if (ACC_W > PROD_W) begin : g_acc_ext
            assign acc_term = {{(ACC_W-PROD_W){prod_mul[PROD_W-1]}}, prod_mul};
        end else begin : g_acc_trunc
            assign acc_term = prod_mul[ACC_W-1:0];
        end
    endgenerate

`ifdef DET_OVERFLOW_CHECK_EN
    logic [ACC_W-DET_W:0] acc_top;
    assign acc_top = acc_reg[ACC_W-1:DET_W-1];
    assign ovf_now = !((&acc_top) || !(|acc_top));
`else
    assign ovf_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gen_init   = 1'b0;
        gen_step   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = bad_n ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                gen_init   = 1'b1;
                state_next = ST_MUL;
            end
            ST_MUL: begin
                if (last_mul) begin
                    if (gen_last) begin
                        state_next = ST_DONE;
                    end else begin
                        gen_step = 1'b1;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mat_reg     <= '0;
            n_reg       <= '0;
            j_reg       <= '0;
            prod_reg    <= '0;
            acc_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            job_err_reg <= 1'b0;
            det_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mat_reg     <= matriz;
                        n_reg       <= n_in;
                        busy_reg    <= 1'b1;
                        job_err_reg <= bad_n;
                        acc_reg     <= '0;
                    end
                end
                ST_LOAD: begin
                    j_reg    <= '0;
                    prod_reg <= PROD_ONE;
                    acc_reg  <= '0;
                end
                ST_MUL: begin
                    if (last_mul) begin
                        acc_reg <= acc_reg + acc_term;
                        j_reg   <= '0;
                        // Successive Heap's permutations differ by one swap,
                        // so the next sign is the opposite of the current one.
                        prod_reg <= gen_parity ? PROD_ONE : PROD_NEG_ONE;
                    end else begin
                        prod_reg <= prod_mul;
                        j_reg    <= j_reg + N_W'(1);
                    end
                end
                ST_DONE: begin
                    det_reg  <= acc_reg[DET_W-1:0];
                    err_reg  <= job_err_reg;
                    ovf_reg  <= ovf_now;
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign det      = det_reg;
    assign err      = err_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_determinante_seq.sv
// Directed and random checks of determinante_seq against a brute-force
// Leibniz reference (all index tuples, sign from inversion count).
module tb_determinante_seq;

    localparam int MAX_N  = 5;
    localparam int ELEM_W = 8;
    localparam int DET_W  = 32;
    localparam int SIZE_W = 2;
    localparam int MAT_W  = MAX_N * MAX_N * ELEM_W;
    localparam longint DMAX = (64'sd1 <<< 31) - 64'sd1;
    localparam longint DMIN = -(64'sd1 <<< 31);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [SIZE_W-1:0] sinalizador;
    logic [MAT_W-1:0]  matriz;
    logic              busy, done, err, overflow;
    logic [DET_W-1:0]  det;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    determinante_seq #(
        .MAX_N (MAX_N), .ELEM_W (ELEM_W), .DET_W (DET_W), .SIZE_W (SIZE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sinalizador (sinalizador),
        .matriz      (matriz),
        .busy        (busy),
        .done        (done),
        .det         (det),
        .err         (err),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    function automatic longint ref_det(input int n, input int m[25]);
        longint sum = 0;
        int idx[5];
        int total = n ** n;
        for (int t = 0; t < total; t++) begin
            int x = t;
            bit ok = 1'b1;
            int inv = 0;
            longint p = 1;
            for (int r = 0; r < n; r++) begin
                idx[r] = x % n;
                x = x / n;
            end
            for (int r = 0; r < n; r++)
                for (int s = 0; s < r; s++) begin
                    if (idx[s] == idx[r]) ok = 1'b0;
                    if (idx[s] > idx[r]) inv++;
                end
            if (ok) begin
                for (int r = 0; r < n; r++) p = p * m[r*n + idx[r]];
                sum = (inv % 2 == 1) ? sum - p : sum + p;
            end
        end
        return sum;
    endfunction

    function automatic logic [MAT_W-1:0] rand_bits();
        logic [MAT_W-1:0] v;
        for (int b = 0; b < MAT_W; b += 8) v[b +: 8] = 8'($urandom_range(255));
        return v;
    endfunction

    function automatic logic [MAT_W-1:0] pack(input int n, input int m[25]);
        logic [MAT_W-1:0] v = rand_bits();
        for (int k = 0; k < n * n; k++) v[(n*n-1-k)*ELEM_W +: ELEM_W] = 8'(m[k]);
        return v;
    endfunction

    task automatic mk(input int q[$], output int m[25]);
        for (int k = 0; k < 25; k++) m[k] = (k < q.size()) ? q[k] : 0;
    endtask

    task automatic launch(input int n, input int m[25]);
        @(negedge clk);
        sinalizador = SIZE_W'(n - 2);
        matriz      = pack(n, m);
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        matriz = rand_bits();
    endtask

    // poke_at >= 0 pulses start (with a different matrix) while busy.
    task automatic run_job(input string tag, input int n, input int m[25],
                           input longint exp_det, input int poke_at);
        int cycles = 0;
        int extra_done = 0;
        int extra_busy = 0;
        bit seen = 1'b0;
        bit exp_ovf = 1'b0;
`ifdef DET_OVERFLOW_CHECK_EN
        exp_ovf = (exp_det > DMAX) || (exp_det < DMIN);
`endif
        launch(n, m);
        check({tag, " busy"}, longint'(busy), 1);
        while (!seen && cycles < 2000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (cycles == poke_at) begin
                start  = 1'b1;
                matriz = rand_bits();
            end else start = 1'b0;
        end
        start = 1'b0;
        $display("[TB] %s n=%0d cycles=%0d det=%0d err=%0b ovf=%0b",
                 tag, n, cycles, $signed(det), err, overflow);
        check({tag, " done"}, longint'(seen), 1);
        check({tag, " latency"}, cycles, fact(n) * n + 2);
        check({tag, " det"}, longint'($signed(det)), longint'(int'(exp_det)));
        check({tag, " err"}, longint'(err), 0);
        check({tag, " overflow"}, longint'(overflow), longint'(exp_ovf));
        check({tag, " busy_at_done"}, longint'(busy), 0);
        repeat (4) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check({tag, " single_done"}, extra_done, 0);
        check({tag, " idle_after"}, extra_busy, 0);
        check({tag, " det_held"}, longint'($signed(det)), longint'(int'(exp_det)));
    endtask

    initial begin
        int m[25];
        int q[$];
        int dones;
        rst = 1'b1;
        start = 1'b0;
        sinalizador = '0;
        matriz = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check("reset det", longint'(det), 0);
        check("reset err", longint'(err), 0);
        check("reset overflow", longint'(overflow), 0);

        mk('{2, 3, 1, 4}, m);
        run_job("d2x2", 2, m, 5, -1);
        mk('{2, -3, 1, 4, 5, 6, 7, 8, 9}, m);
        run_job("d3x3", 3, m, -27, -1);
        mk('{1, 2, 3, 4, 2, 4, 6, 8, 3, 1, 5, 7, 4, 3, 8, 2}, m);
        run_job("d4x4", 4, m, 0, -1);
        mk('{2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 6}, m);
        run_job("d5x5_poke", 5, m, 720, 100);

        // Abort a 5x5 job with reset at cycle 50.
        launch(5, m);
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", longint'(busy), 0);
        check("abort done", longint'(done), 0);
        check("abort det", longint'(det), 0);
        dones = 0;
        repeat (700) begin
            @(negedge clk);
            if (done) dones++;
        end
        $display("[TB] abort dones_after_reset=%0d busy=%0b", dones, busy);
        check("abort no_done", dones, 0);
        mk('{2, 3, 1, 4}, m);
        run_job("after_abort", 2, m, 5, -1);

        q = {};
        for (int k = 0; k < 25; k++) q.push_back((k % 6 == 0) ? -128 : 0);
        mk(q, m);
        run_job("neg128_diag", 5, m, ref_det(5, m), -1);

        for (int t = 0; t < 12; t++) begin
            int n = int'($urandom_range(5, 2));
            for (int k = 0; k < 25; k++) m[k] = int'($urandom_range(255)) - 128;
            run_job($sformatf("rand%0d", t), n, m, ref_det(n, m), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/determinante_seq.md
# determinante_seq

- Sequential, parametrised successor to the combinational determinant unit.
- Computes the signed determinant of an n×n integer matrix, n = 2..MAX_N, by Leibniz expansion.
  - Permutations are enumerated by an internal Heap's-algorithm generator.
  - Each product is accumulated one multiply per cycle.
- Sits in the operations datapath behind a start/done handshake and replaces the area-heavy combinational determinant for large n.

## Interface

Parameters:
- MAX_N, 5: largest supported matrix order.
- ELEM_W, 8: signed element width.
- DET_W, 32: signed result width.
- SIZE_W, 2: width of sinalizador.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only while busy=0.
- sinalizador  in  SIZE_W  order select, n = sinalizador + 2.
- matriz  in  MAX_N·MAX_N·ELEM_W  signed elements.
  - Row-major, index k = r·n + c.
  - Element k sits at bits [(n·n−1−k)·ELEM_W +: ELEM_W], so the first element is in the MSBs of the low n·n·ELEM_W bits.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse, result valid.
- det  out  DET_W  signed determinant; held until next accepted start.
- err  out  1  invalid order (n > MAX_N); valid with done.
- overflow  out  1  result did not fit DET_W; valid with done.

## Operation

- States: IDLE, LOAD, MUL, ACC, DONE.
- **IDLE:**
  - start=1 latches matriz and n, then goes to LOAD.
  - If n > MAX_N, goes to DONE with err=1 and det=0.
- **LOAD:**
  - Resets the generator to the identity permutation, parity +1.
  - Clears the accumulator.
  - Loads the product register with ±1 from parity.
- **MUL:**
  - Each cycle, product ← product · a[j][perm[j]] for j = 0..n−1, so n cycles per permutation.
  - Product width is ELEM_W·MAX_N.
  - The generator computes the next permutation and its parity in parallel.
  - Heap's algorithm needs at most n−1 non-emitting steps between outputs, so the next permutation is always ready before MUL ends.
- **ACC:** folded into the last MUL cycle.
  - accumulator += product.
  - If this was the last permutation, go to DONE; otherwise reload the product with the next sign and continue MUL.
- **DONE:**
  - det ← accumulator[DET_W−1:0].
  - done=1 for one cycle, busy=0, return to IDLE.
- start while busy=1 is ignored; no queueing.
- start in the DONE cycle is ignored.
- Inputs may change freely after acceptance.

## Timing

- Reset values: busy=0, done=0, det=0, err=0, overflow=0; state IDLE.
- done asserts exactly n!·n + 2 cycles after the edge that sampled start:
  - 2×2: 6
  - 3×3: 20
  - 4×4: 98
  - 5×5: 602
- Invalid-order error: done asserts 1 cycle after start, with err=1.
- rst mid-operation:
  - Returns to IDLE next edge with all outputs at reset values.
  - No done for the aborted job.
- det, err and overflow are stable from done until the next accepted start.

## Configuration

- DET_OVERFLOW_CHECK_EN defined:
  - Accumulator width is ELEM_W·MAX_N + ceil(log2(MAX_N!)) + 1 (48 at defaults).
  - overflow=1 if the final sum is not representable in signed DET_W.
  - det is always the low DET_W bits.
- Not defined:
  - Accumulator is DET_W wide and wraps modulo 2^DET_W.
  - overflow is tied 0.

## Structure

- Package det_pkg holds:
  - state enum;
  - factorial function;
  - derived widths (PROD_W, ACC_W, PERM_IDX_W).
- Sub-module heap_perm_gen contains the iterative Heap's generator.
  - Inputs: clk, rst, init, step, n.
  - Outputs: perm (MAX_N indices), parity, last.
- Top level holds the FSM, element mux, multiplier and accumulator.

## Test plan

- 2×2 {2,3,1,4}, sinalizador=00 → det=5, done at cycle 6, err=0.
- 3×3 {2,−3,1,4,5,6,7,8,9}, sinalizador=01 → det=−27 at cycle 20.
- 4×4 {1,2,3,4, 2,4,6,8, 3,1,5,7, 4,3,8,2}, sinalizador=10 → det=0 at cycle 98.
  - Rows 0 and 1 are dependent.
- 5×5 diagonal {2,3,4,5,6}, zeros elsewhere, sinalizador=11 → det=720 at cycle 602.
  - Pulse start again at cycle 100: it is ignored.
- 5×5 diagonal of −128:
  - With DET_OVERFLOW_CHECK_EN: overflow=1, det=0 (low 32 bits of −2^35).
  - Without it: overflow=0, det=0.
- Start a 5×5 job, assert rst at cycle 50 → busy=0 next cycle and no done.
  - Then a 2×2 {2,3,1,4} job → det=5 at cycle 6.
